mtr_drv_n: RTL and testbench

Multi-channel complementary PWM motor driver: the parametrised successor to our two-channel fixed-width motor drive. Each channel converts a signed speed command into a duty cycle centred at 50 %. Each channel's duty cycle is slew-limited once per PWM period. Each channel drives a non-overlapping PWM pair with programmable dead time. The block sits between the speed/steering controller and the H-bridge pins, and exports a period strobe so upstream control loops can lock to the PWM frame.

---
 rtl/mtr_drv_n.sv | 56 +++++
 tb/tb_mtr_drv_n.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mtr_drv_n.sv
// mtr_drv_n: slew-limited complementary PWM pairs with dead time (clk, rst_n, en, spd in; pwm1, pwm2, period_strobe, at_target out)
module mtr_drv_n #(
  parameter int NUM_CH = 2,
  parameter int SPD_W  = 11,
  parameter int DEAD   = 4,
  parameter int SLEW   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [NUM_CH*SPD_W-1:0] spd,
  output logic [NUM_CH-1:0]       pwm1,
  output logic [NUM_CH-1:0]       pwm2,
  output logic                    period_strobe,
  output logic [NUM_CH-1:0]       at_target
);
  localparam logic [SPD_W-1:0] MID = {1'b1, {(SPD_W-1){1'b0}}};
  localparam logic [SPD_W-1:0] STP = SPD_W'(SLEW);
  localparam logic [SPD_W:0]   DW  = (SPD_W+1)'(DEAD);
  localparam logic [SPD_W:0]   SW  = (SPD_W+1)'(SLEW);
  logic [SPD_W-1:0] r_cnt;
  logic [SPD_W-1:0] r_duty [NUM_CH];
  logic [SPD_W-1:0] w_tgt  [NUM_CH];
  logic [SPD_W-1:0] w_nxt  [NUM_CH];
  logic [SPD_W:0]   w_diff [NUM_CH];
  logic [SPD_W:0]   w_mag  [NUM_CH];
  logic [NUM_CH-1:0] w_p1, w_p2, w_at;
  logic w_last;
  assign w_last = &r_cnt;
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign w_tgt[g]  = spd[g*SPD_W +: SPD_W] ^ MID;
    assign w_diff[g] = {1'b0, w_tgt[g]} - {1'b0, r_duty[g]};
    assign w_mag[g]  = w_diff[g][SPD_W] ? -w_diff[g] : w_diff[g];
    assign w_nxt[g]  = (SLEW == 0 || w_mag[g] <= SW) ? w_tgt[g] :
                       w_diff[g][SPD_W] ? r_duty[g] - STP : r_duty[g] + STP;
    assign w_p1[g]   = en && {1'b0, r_cnt} >= DW && {1'b0, r_cnt} < {1'b0, r_duty[g]};
    assign w_p2[g]   = en && {1'b0, r_cnt} >= {1'b0, r_duty[g]} + DW;
    assign w_at[g]   = en && r_duty[g] == w_tgt[g];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt         <= '0;
      period_strobe <= 1'b0;
      pwm1          <= '0;
      pwm2          <= '0;
      at_target     <= '0;
      for (int i = 0; i < NUM_CH; i++) r_duty[i] <= MID;
    end else begin
      r_cnt         <= r_cnt + 1'b1;
      period_strobe <= w_last;
      pwm1          <= w_p1;
      pwm2          <= w_p2;
      at_target     <= w_at;
      for (int i = 0; i < NUM_CH; i++) r_duty[i] <= !en ? MID : w_last ? w_nxt[i] : r_duty[i];
    end
endmodule

// File: tb/tb_mtr_drv_n.sv
// tb_mtr_drv_n: scoreboard bench measuring per-period PWM high times against expected duties
module tb_mtr_drv_n;
  typedef struct packed {
    logic [3:0][11:0] d;
    logic [3:0]       a;
  } ent_t;
  logic clk = 1'b0;
  logic rst_n, en;
  logic [21:0] spd;
  logic [43:0] spd2;
  logic [1:0] pwm1, pwm2, at_target;
  logic period_strobe;
  logic [3:0] pwm1b, pwm2b, atb;
  logic strobe_b;
  int total = 0;
  int bad = 0;
  ent_t q1[$];
  ent_t q2[$];
  always #5 clk = ~clk;
  mtr_drv_n dut (
    .clk(clk), .rst_n(rst_n), .en(en), .spd(spd),
    .pwm1(pwm1), .pwm2(pwm2), .period_strobe(period_strobe), .at_target(at_target)
  );
  mtr_drv_n #(.NUM_CH(4), .SLEW(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .spd(spd2),
    .pwm1(pwm1b), .pwm2(pwm2b), .period_strobe(strobe_b), .at_target(atb)
  );
  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  function automatic int hi1(input int d);
    return d > 4 ? d - 4 : 0;
  endfunction
  function automatic int hi2(input int d);
    return d + 4 <= 2047 ? 2048 - d - 4 : 0;
  endfunction
  task automatic setspd(input int s0, input int s1);
    spd[10:0]  = 11'(s0);
    spd[21:11] = 11'(s1);
  endtask
  task automatic exp_push(input int d0, input int d1, input logic [1:0] a);
    ent_t e;
    e = '0;
    e.d[0] = 12'(d0);
    e.d[1] = 12'(d1);
    e.a = {2'b00, a};
    q1.push_back(e);
  endtask
  task automatic wait_strobe();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_strobe && n < 5000);
    chk("strobe_seen", int'(period_strobe), 1);
  endtask
  task automatic frame(input int s0, input int s1, input int d0, input int d1, input logic [1:0] a);
    wait_strobe();
    #2;
    setspd(s0, s1);
    exp_push(d0, d1, a);
  endtask
  initial begin
    int c1[2], c2[2];
    logic [1:0] ap;
    ent_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        c1 = '{0, 0};
        c2 = '{0, 0};
        ap = '0;
      end else begin
        chk("overlap1", int'(pwm1 & pwm2), 0);
        for (int c = 0; c < 2; c++) begin
          c1[c] += int'(pwm1[c]);
          c2[c] += int'(pwm2[c]);
        end
        if (period_strobe) begin
          if (q1.size() > 0) begin
            e = q1.pop_front();
            for (int c = 0; c < 2; c++) begin
              chk($sformatf("d1_pwm1_hi_ch%0d", c), c1[c], hi1(int'(e.d[c])));
              chk($sformatf("d1_pwm2_hi_ch%0d", c), c2[c], hi2(int'(e.d[c])));
              chk($sformatf("d1_at_target_ch%0d", c), int'(ap[c]), int'(e.a[c]));
            end
          end
          c1 = '{0, 0};
          c2 = '{0, 0};
        end
        ap = at_target;
      end
    end
  end
  initial begin
    int c1[4], c2[4];
    logic [3:0] ap;
    ent_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        c1 = '{0, 0, 0, 0};
        c2 = '{0, 0, 0, 0};
        ap = '0;
      end else begin
        chk("overlap2", int'(pwm1b & pwm2b), 0);
        for (int c = 0; c < 4; c++) begin
          c1[c] += int'(pwm1b[c]);
          c2[c] += int'(pwm2b[c]);
        end
        if (strobe_b) begin
          if (q2.size() > 0) begin
            e = q2.pop_front();
            for (int c = 0; c < 4; c++) begin
              chk($sformatf("d2_pwm1_hi_ch%0d", c), c1[c], hi1(int'(e.d[c])));
              chk($sformatf("d2_pwm2_hi_ch%0d", c), c2[c], hi2(int'(e.d[c])));
              chk($sformatf("d2_at_target_ch%0d", c), int'(ap[c]), int'(e.a[c]));
            end
          end
          c1 = '{0, 0, 0, 0};
          c2 = '{0, 0, 0, 0};
        end
        ap = atb;
      end
    end
  end
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    ent_t e;
    int n;
    rst_n = 1'b0;
    en = 1'b1;
    setspd(0, 0);
    spd2 = {11'h6D4, 11'h000, 11'h3FF, 11'h400};
    e = '0;
    e.d = {12'd1024, 12'd1024, 12'd1024, 12'd1024};
    e.a = 4'b0100;
    q2.push_back(e);
    e.d = {12'd724, 12'd1024, 12'd2047, 12'd0};
    e.a = 4'b1111;
    q2.push_back(e);
    exp_push(1024, 1024, 2'b11);
    repeat (3) @(negedge clk);
    chk("rst_pwm1", int'(pwm1), 0);
    chk("rst_pwm2", int'(pwm2), 0);
    chk("rst_strobe", int'(period_strobe), 0);
    chk("rst_at_target", int'(at_target), 0);
    rst_n = 1'b1;
    frame(0, 0, 1024, 1024, 2'b11);
    frame(512, 0, 1024, 1024, 2'b10);
    for (int k = 1; k <= 4; k++) frame(512, 0, 1024 + 16 * k, 1024, 2'b10);
    frame(100, -50, 1104, 1024, 2'b00);
    frame(100, -50, 1120, 1008, 2'b00);
    frame(100, -50, 1124, 992, 2'b01);
    frame(100, -50, 1124, 976, 2'b01);
    frame(100, -50, 1124, 974, 2'b11);
    wait_strobe();
    #2;
    setspd(512, 0);
    wait_strobe();
    repeat (300) @(negedge clk);
    chk("pre_en_drop_pwm1", int'(pwm1[0]), 1);
    en = 1'b0;
    @(negedge clk);
    chk("en_low_pwm1", int'(pwm1), 0);
    chk("en_low_pwm2", int'(pwm2), 0);
    chk("en_low_at_target", int'(at_target), 0);
    repeat (50) @(negedge clk);
    en = 1'b1;
    frame(512, 0, 1040, 1024, 2'b10);
    frame(512, 0, 1056, 1024, 2'b10);
    wait_strobe();
    repeat (700) @(negedge clk);
    chk("pre_reset_pwm1", int'(pwm1[0]), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_pwm1", int'(pwm1), 0);
    chk("async_rst_pwm2", int'(pwm2), 0);
    chk("async_rst_strobe", int'(period_strobe), 0);
    chk("async_rst_at_target", int'(at_target), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_push(1024, 1024, 2'b10);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_strobe && n < 5000);
    chk("release_to_strobe_clocks", n, 2048);
    #2;
    exp_push(1040, 1024, 2'b10);
    wait_strobe();
    #2;
    chk("queues_drained", q1.size() + q2.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
